// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - OPB slave bank of software-writable 32-bit control registers
// Define OPB_REGBANK_SHADOW_EN for shadow registers with an atomic commit address at offset C_NUM_REGS.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR     = 32'h01030100,
  parameter logic [31:0] C_HIGHADDR     = 32'h010301FF,
  parameter int          C_OPB_AWIDTH   = 32,
  parameter int          C_OPB_DWIDTH   = 32,
  parameter int          C_NUM_REGS     = 8,
  parameter logic [31:0] C_RESET_VAL    = 32'h0,
  parameter logic [63:0] C_AUTOCLR_MASK = 64'h0,
  parameter string       C_FAMILY       = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:3]                  OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]    user_data_out,
  output logic [C_NUM_REGS-1:0]       user_wr_strobe
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                state;
  logic [31:0]           abus;
  logic [31:0]           wdata;
  logic [31:0]           diff;
  logic [31:0]           off;
  logic [31:0]           rdata;
  logic [31:0]           dbus_q;
  logic [3:0]            be;
  logic                  decode;
  logic                  wr_en;
  logic                  ack_q;
  logic                  unused_bits;
  logic [31:0]           out_q [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] strobe_q;
`ifdef OPB_REGBANK_SHADOW_EN
  logic [31:0]           shadow_q [C_NUM_REGS];
  logic [7:0]            commit_cnt;
`endif

  // Big-endian bus vectors map MSB-first onto little-endian locals: BE[0] lands in be[3] (bits 31:24).
  assign abus  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be    = OPB_BE;
  assign diff  = abus - C_BASEADDR;
  assign off   = {2'b00, diff[31:2]};

  assign decode = (state == IDLE) && OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign wr_en  = decode && !OPB_RNW;

  assign unused_bits = ^{OPB_seqAddr, diff[1:0]};

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] data,
                                           input logic [3:0] en);
    logic [31:0] m;
    m = {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
    return (old & ~m) | (data & m);
  endfunction

  always_comb begin
    rdata = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (off == 32'(i)) begin
`ifdef OPB_REGBANK_SHADOW_EN
        rdata = shadow_q[i];
`else
        rdata = out_q[i];
`endif
      end
    end
`ifdef OPB_REGBANK_SHADOW_EN
    if (off == 32'(C_NUM_REGS)) rdata = {24'b0, commit_cnt};
`endif
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state    <= IDLE;
      ack_q    <= 1'b0;
      dbus_q   <= '0;
      strobe_q <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) out_q[i] <= C_RESET_VAL;
`ifdef OPB_REGBANK_SHADOW_EN
      for (int i = 0; i < C_NUM_REGS; i++) shadow_q[i] <= C_RESET_VAL;
      commit_cnt <= 8'd0;
`endif
    end else begin
      ack_q    <= decode;
      dbus_q   <= (decode && OPB_RNW) ? rdata : 32'h0;
      strobe_q <= '0;
      case (state)
        IDLE:    if (decode) state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
      // Pulse registers fall back every cycle; a same-cycle write below overrides this.
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (C_AUTOCLR_MASK[i]) out_q[i] <= C_RESET_VAL;
      end
`ifdef OPB_REGBANK_SHADOW_EN
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr_en && off == 32'(i)) shadow_q[i] <= merge_be(shadow_q[i], wdata, be);
      end
      if (wr_en && off == 32'(C_NUM_REGS)) begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
          out_q[i] <= shadow_q[i];
          // A committed pulse must not fire again on the next commit.
          if (C_AUTOCLR_MASK[i]) shadow_q[i] <= C_RESET_VAL;
        end
        strobe_q   <= '1;
        commit_cnt <= commit_cnt + 8'd1;
      end
`else
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr_en && off == 32'(i)) begin
          out_q[i]    <= merge_be(out_q[i], wdata, be);
          strobe_q[i] <= 1'b1;
        end
      end
`endif
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[g*32 +: 32] = out_q[g];
  end

  assign Sl_DBus        = dbus_q;
  assign Sl_xferAck     = ack_q;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;
  assign user_wr_strobe = strobe_q;

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
# opb_register_bank_ppc2simulink

Parametrised OPB slave holding C_NUM_REGS software-writable 32-bit control registers, driven onto fabric user logic. It is the multi-register successor to the single ppc2simulink register. It adds byte-enable writes, readback, per-register write strobes, self-clearing (pulse) registers and optional atomic shadow commit. It sits on the PPC OPB bus, and its outputs feed DSP control inputs in the same clock domain.

## Interface
- C_BASEADDR, 32'h01030100: first byte address of the bank.
- C_HIGHADDR, 32'h010301FF: last byte address decoded.
- C_OPB_AWIDTH, 32: address width.
- C_OPB_DWIDTH, 32: data width. Only 32 is supported.
- C_NUM_REGS, 8: number of registers, 1..63.
- C_RESET_VAL, 32'h0: reset value of every register.
- C_AUTOCLR_MASK, 0: bit i set means register i is a pulse register.
- C_FAMILY, "virtex5": target family.
- OPB_Clk  in  1  the single clock for the bus and user side.
- OPB_Rst_n  in  1  reset, synchronous and active-low.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables. BE[0] selects DBus[0:7], which is register bits [31:24].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 means read.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data. It is 0 whenever Sl_xferAck is 0.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0.
- user_data_out  out  [C_NUM_REGS*32-1:0]  register i occupies bits [32i+31:32i].
- user_wr_strobe  out  [C_NUM_REGS-1:0]  one-cycle pulse when register i's output value is updated by software.

## Operation
- Word offset = (OPB_ABus − C_BASEADDR) >> 2.
- A transfer is decoded only when OPB_select=1 and C_BASEADDR ≤ OPB_ABus ≤ C_HIGHADDR.
- The FSM has two states, IDLE and ACK.
  - IDLE→ACK on a decoded transfer.
  - ACK→IDLE unconditionally.
  - A transfer still selected in ACK is not re-decoded. A back-to-back transfer is accepted in the following IDLE cycle, so throughput is 2 cycles per transfer.
- Write to offset i < C_NUM_REGS: update only the bytes whose OPB_BE bit is 1.
- Read of offset i < C_NUM_REGS: return the written value. That is the shadow value when shadowing is enabled, otherwise the output value.
- Out-of-range offsets inside the decoded window:
  - Writes are ignored.
  - Reads return 0.
  - Both are still acked.
  - Exception: offset C_NUM_REGS with shadowing enabled is the commit address (see Configuration).
- Pulse registers (C_AUTOCLR_MASK[i]=1): the output holds the written value for exactly one cycle, then returns to C_RESET_VAL.
  - A new write in that cycle takes priority over the clear.
  - Readback of a pulse register always returns C_RESET_VAL, except in the cycle the written value is held.
- Reset (OPB_Rst_n=0 at a clock edge) applies even in the middle of a transfer:
  - FSM→IDLE.
  - Sl_xferAck=0, Sl_DBus=0.
  - All registers and shadows = C_RESET_VAL.
  - user_wr_strobe=0.
  - Commit counter = 0.
  - A transfer in flight is dropped without ack. The master times out.

## Timing
- Decoded transfer in cycle T (IDLE): Sl_xferAck=1 in T+1 only.
- On a read, Sl_DBus is valid in T+1.
- On a write, the register changes at the edge ending T. user_data_out shows the new value in T+1, and user_wr_strobe[i]=1 in T+1.
- A pulse register's output reverts in T+2.
- Read data comes from a register, so Sl_DBus is glitch-free.

## Configuration
Macro: OPB_REGBANK_SHADOW_EN.
- When defined:
  - Writes land in shadow registers, and user_data_out is unchanged.
  - A write to offset C_NUM_REGS (data ignored) copies all shadows to the outputs at the edge ending T.
  - All user_wr_strobe bits pulse in T+1.
  - An 8-bit commit counter increments and wraps 255→0.
  - Reading offset C_NUM_REGS returns {24'b0, counter}.
  - Pulse registers clear one cycle after commit.
- When undefined:
  - Writes go directly to the outputs.
  - Offset C_NUM_REGS behaves like any other out-of-range offset.
  - The shadow storage and the counter are absent.

## Test plan
- Reset, then write 32'hDEADBEEF to offset 2 with BE=1111, then read it back:
  - Ack in T+1.
  - user_data_out[95:64]=DEADBEEF in T+1.
  - user_wr_strobe=8'b00000100 for one cycle.
  - Read returns DEADBEEF.
- Offset 2 holds DEADBEEF; write 32'h12345678 with BE=0101: register = DE34BE78.
- C_AUTOCLR_MASK=1, write 32'h1 to offset 0: output is 1 in T+1 only and 0 in T+2. A read one cycle later returns 0.
- Read offset 0x3C (out of range, inside the window): acked, returns 0, and no register changes. An address above C_HIGHADDR gets no ack.
- With OPB_REGBANK_SHADOW_EN: write 0xAA to offset 1 → output is still 0 and a read returns 0xAA. Then write offset 8 → output = 0xAA, all 8 strobes pulse, and reading offset 8 returns 1. After 256 commits, the read returns 0.
- Assert OPB_Rst_n=0 in T while a write is selected: no ack, all outputs = C_RESET_VAL, FSM in IDLE. After release, a fresh transfer is acked normally.
